// File: rtl/dha_arb_pack.sv
// Purpose: shared types, widths and helpers for the dynamic header adder source arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_t, src_id_t, DATA_BITS / EMPTY_BITS for the default build,
//           min1_clog2() width helper and cyc_dist() round-robin distance helper.
package dha_arb_pack;

  localparam int DEF_DW_BYTES  = 4;
  localparam int DEF_NUM_SRC   = 4;
  localparam int DEF_MAX_STALL = 64;

  // Width of an index/count field that must be at least one bit wide.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DATA_BITS   = 8 * DEF_DW_BYTES;
  localparam int EMPTY_BITS  = min1_clog2(DEF_DW_BYTES);
  localparam int SRC_ID_BITS = min1_clog2(DEF_NUM_SRC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PKT   = 2'd1,
    ABORT = 2'd2
  } state_t;

  typedef logic [SRC_ID_BITS-1:0] src_id_t;

  // Number of steps going forward (cyclically) from 'from' to reach 'to'.
  function automatic int cyc_dist(input int from, input int to, input int n);
    return (to - from + n) % n;
  endfunction

endpackage

// File: rtl/dha_rr_pick.sv
// Purpose: round-robin picker - first set request at or after rr_ptr_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; caller decides when to register the pick.
// Ports: req_i (request vector), rr_ptr_i (priority start), found_o (any request), idx_o (winner).
module dha_rr_pick
  import dha_arb_pack::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  localparam int IW = min1_clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IW-1:0]      rr_ptr_i,
  output logic               found_o,
  output logic [IW-1:0]      idx_o
);

  int best;

  // Smallest cyclic distance from the pointer wins; strict '<' keeps the
  // first one found at each distance, and distances are all distinct anyway.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    best    = NUM_SRC;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req_i[i] && (cyc_dist(int'(rr_ptr_i), i, NUM_SRC) < best)) begin
        best    = cyc_dist(int'(rr_ptr_i), i, NUM_SRC);
        idx_o   = IW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dha_src_arbiter.sv
// Purpose: packet-granular round-robin arbiter sharing one header-adder datapath among NUM_SRC sources.
// Latency: one idle (grant) cycle per packet, then zero-latency pass-through of the granted source.
// Backpressure: out_ready is forwarded combinationally to in_ready of the granted source only.
// Ports: clk/rst (sync, active-high); per-source in_valid/in_ready/in_sop/in_eop/in_data/in_empty;
//        out_valid/out_ready/out_sop/out_eop/out_data/out_empty/out_src_id/out_err to the adder; busy.
// Option: define DHA_ARB_WATCHDOG_EN to add the stall watchdog, ABORT state and per-source drain.
module dha_src_arbiter
  import dha_arb_pack::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = DEF_DW_BYTES,
  parameter int NUM_SRC             = DEF_NUM_SRC,
  parameter int MAX_STALL           = DEF_MAX_STALL,
  localparam int DW_BITS = 8 * DATA_WIDTH_IN_BYTES,
  localparam int EW      = min1_clog2(DATA_WIDTH_IN_BYTES),
  localparam int IW      = min1_clog2(NUM_SRC)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC-1:0]              in_valid,
  output logic [NUM_SRC-1:0]              in_ready,
  input  logic [NUM_SRC-1:0]              in_sop,
  input  logic [NUM_SRC-1:0]              in_eop,
  input  logic [NUM_SRC-1:0][DW_BITS-1:0] in_data,
  input  logic [NUM_SRC-1:0][EW-1:0]      in_empty,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_sop,
  output logic                            out_eop,
  output logic [DW_BITS-1:0]              out_data,
  output logic [EW-1:0]                   out_empty,
  output logic [IW-1:0]                   out_src_id,
  output logic                            out_err,
  output logic                            busy
);

  state_t          state_q, state_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_SRC-1:0] req;
  logic            found;
  logic [IW-1:0]   pick_idx;
  logic            eop_hs;
  logic [IW-1:0]   ptr_after_gnt;
  logic            stall_hit;
  logic [NUM_SRC-1:0] drain;

`ifdef DHA_ARB_WATCHDOG_EN
  localparam int SW = $clog2(MAX_STALL + 1);

  logic [SW-1:0]      stall_q, stall_d;
  logic [NUM_SRC-1:0] drain_q, drain_d;

  // Counts consecutive PKT cycles where the granted source has no beat.
  always_comb begin
    stall_d   = '0;
    stall_hit = 1'b0;
    if (state_q == PKT && !in_valid[gnt_q]) begin
      stall_d   = stall_q + SW'(1);
      stall_hit = (int'(stall_q) + 1 == MAX_STALL);
    end
  end

  // A source aborted by the watchdog keeps sending the rest of its packet;
  // those beats are swallowed until its EOP goes by.
  always_comb begin
    drain_d = drain_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (drain_q[i] && in_valid[i] && in_eop[i]) drain_d[i] = 1'b0;
    end
    if (stall_hit) drain_d[gnt_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      drain_q <= '0;
    end else begin
      stall_q <= stall_d;
      drain_q <= drain_d;
    end
  end

  assign drain = drain_q;
`else
  logic [31:0] unused_max_stall;
  assign unused_max_stall = 32'(MAX_STALL);
  assign stall_hit        = 1'b0;
  assign drain            = '0;
`endif

  // Only packet starts compete; draining sources sit out.
  assign req = in_valid & in_sop & ~drain;

  dha_rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .found_o  (found),
    .idx_o    (pick_idx)
  );

  assign eop_hs        = (state_q == PKT) && in_valid[gnt_q] && in_eop[gnt_q] && out_ready;
  assign ptr_after_gnt = (gnt_q == IW'(NUM_SRC - 1)) ? '0 : gnt_q + IW'(1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = PKT;
          gnt_d   = pick_idx;
        end
      end
      PKT: begin
        if (eop_hs) begin
          state_d  = IDLE;
          rr_ptr_d = ptr_after_gnt;
        end else if (stall_hit) begin
          state_d = ABORT;
        end
      end
`ifdef DHA_ARB_WATCHDOG_EN
      ABORT: begin
        // The aborted packet counts as this source's turn.
        if (out_ready) begin
          state_d  = IDLE;
          rr_ptr_d = ptr_after_gnt;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready   = drain;
    out_valid  = 1'b0;
    out_sop    = 1'b0;
    out_eop    = 1'b0;
    out_data   = '0;
    out_empty  = '0;
    out_err    = 1'b0;
    out_src_id = gnt_q;
    busy       = (state_q != IDLE);
    case (state_q)
      PKT: begin
        out_valid       = in_valid[gnt_q];
        out_sop         = in_sop[gnt_q];
        out_eop         = in_eop[gnt_q];
        out_data        = in_data[gnt_q];
        out_empty       = in_empty[gnt_q];
        in_ready[gnt_q] = out_ready;
      end
`ifdef DHA_ARB_WATCHDOG_EN
      ABORT: begin
        // Synthetic terminating beat so the adder closes the packet cleanly.
        out_valid = 1'b1;
        out_eop   = 1'b1;
        out_err   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dha_src_arbiter.sv
module tb_dha_src_arbiter;

  localparam int NS = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     in_valid, in_ready, in_sop, in_eop;
  logic [NS-1:0][31:0] in_data;
  logic [NS-1:0][1:0]  in_empty;
  logic              out_valid, out_ready, out_sop, out_eop, out_err, busy;
  logic [31:0]       out_data;
  logic [1:0]        out_empty, out_src_id;

  always #5 clk = ~clk;

  dha_src_arbiter #(
    .DATA_WIDTH_IN_BYTES (4),
    .NUM_SRC             (NS),
    .MAX_STALL           (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_data    (in_data),
    .in_empty   (in_empty),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .out_data   (out_data),
    .out_empty  (out_empty),
    .out_src_id (out_src_id),
    .out_err    (out_err),
    .busy       (busy)
  );

  typedef struct {
    int         src;
    logic       sop;
    logic       eop;
    logic [31:0] data;
    logic [1:0] empty;
    logic       err;
    int         dly;
  } beat_t;

  beat_t src_q [NS][$];
  beat_t exp_q [$];

  int checks = 0;
  int errors = 0;
  int pop_cnt  [NS];
  int wait_cnt [NS];
  logic [NS-1:0] hs_q;
  logic toggle_rdy = 1'b0;
  logic rdy_level  = 1'b0;
  logic gap_chk    = 1'b0;
  int   last_eop   = -1;
  int   cyc        = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_pkt(input int s, input int n, input int tag, input logic [1:0] emp,
                          input int stall_beat, input int stall_len, input int n_exp);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.src   = s;
      b.sop   = (k == 0);
      b.eop   = (k == n - 1);
      b.data  = (32'(s) << 24) | (32'(tag) << 8) | 32'(k);
      b.empty = (k == n - 1) ? emp : 2'd0;
      b.err   = 1'b0;
      b.dly   = (k == stall_beat) ? stall_len : 0;
      src_q[s].push_back(b);
      if (k < n_exp) exp_q.push_back(b);
    end
  endtask

  task automatic wait_drain(input int budget);
    bit done;
    done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk); #3;
      done = (exp_q.size() == 0);
      for (int i = 0; i < NS; i++) if (src_q[i].size() != 0) done = 0;
    end
    chk("drain_exp_left", 64'(exp_q.size()), 64'd0);
    chk("drain_src_left", 64'(src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()), 64'd0);
    repeat (2) @(negedge clk);
    #3;
  endtask

  // Source drivers and out_ready generator
  initial begin
    in_valid  = '0; in_sop = '0; in_eop = '0; in_data = '0; in_empty = '0;
    out_ready = 1'b0;
    hs_q      = '0;
    for (int i = 0; i < NS; i++) begin pop_cnt[i] = 0; wait_cnt[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        if (hs_q[i] && src_q[i].size() > 0) begin
          void'(src_q[i].pop_front());
          pop_cnt[i]++;
          wait_cnt[i] = (src_q[i].size() > 0) ? src_q[i][0].dly : 0;
        end else if (wait_cnt[i] > 0) begin
          wait_cnt[i]--;
        end
        if (src_q[i].size() > 0) begin
          in_valid[i] = (wait_cnt[i] == 0);
          in_sop[i]   = src_q[i][0].sop;
          in_eop[i]   = src_q[i][0].eop;
          in_data[i]  = src_q[i][0].data;
          in_empty[i] = src_q[i][0].empty;
        end else begin
          in_valid[i] = 1'b0; in_sop[i] = 1'b0; in_eop[i] = 1'b0;
          in_data[i]  = '0;   in_empty[i] = '0;
        end
      end
      out_ready = toggle_rdy ? ~out_ready : rdy_level;
      #1;
      hs_q = in_valid & in_ready;
    end
  end

  // Monitor / scoreboard
  initial begin
    beat_t e;
    forever begin
      @(negedge clk); #2;
      cyc++;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: src %0d data %h with nothing expected", out_src_id, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {24'd0, busy, out_src_id, out_sop, out_eop, out_err, out_empty, out_data},
                      {24'd0, 1'b1, 2'(e.src), e.sop, e.eop, e.err, e.empty, e.data});
        end
        if (gap_chk) begin
          if (out_sop && last_eop >= 0) chk("pkt_gap", 64'(cyc - last_eop), 64'd2);
          if (out_eop) last_eop = cyc;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    beat_t ab;
    int start;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(out_err), 64'd0);
    rst = 1'b0;

    // Idle: nothing requested
    repeat (10) begin
      @(negedge clk); #3;
      chk("idle_outputs", {59'd0, in_ready, out_valid}, 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
    end

    // All four sources start together: 0,1,2,3 with one bubble each
    rdy_level = 1'b1;
    gap_chk = 1'b1; last_eop = -1;
    for (int s = 0; s < NS; s++) send_pkt(s, 3, 16 + s, 2'd0, -1, 0, 3);
    wait_drain(200);
    gap_chk = 1'b0;

    // Src 2 back-to-back with toggling ready; empty=3 on EOP
    toggle_rdy = 1'b1;
    send_pkt(2, 4, 32, 2'd3, -1, 0, 4);
    send_pkt(2, 4, 33, 2'd3, -1, 0, 4);
    wait_drain(200);
    toggle_rdy = 1'b0;

    // Pointer now 3: src 3 before src 0
    send_pkt(3, 2, 48, 2'd1, -1, 0, 2);
    send_pkt(0, 2, 49, 2'd2, -1, 0, 2);
    wait_drain(200);

    // Single requester (pointer 1): src 1 twice, one bubble between
    gap_chk = 1'b1; last_eop = -1;
    send_pkt(1, 2, 64, 2'd0, -1, 0, 2);
    send_pkt(1, 2, 65, 2'd0, -1, 0, 2);
    wait_drain(200);
    gap_chk = 1'b0;

    // Reset mid-packet (pointer 2): src 2 five beats, reset after beat 1
    send_pkt(2, 5, 80, 2'd0, 2, 2, 2);
    start = pop_cnt[2];
    for (int k = 0; k < 100 && pop_cnt[2] < start + 2; k++) begin
      @(negedge clk); #3;
    end
    chk("rst_pkt_beats_taken", 64'(pop_cnt[2] - start), 64'd2);
    rst = 1'b1;
    @(negedge clk); #3;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_outputs", {59'd0, in_ready, out_valid}, 64'd0);
    src_q[2].delete();
    wait_cnt[2] = 0;
    rst = 1'b0;
    // Pointer back at 0: src 1 wins over src 3
    send_pkt(1, 2, 96, 2'd0, -1, 0, 2);
    send_pkt(3, 2, 97, 2'd0, -1, 0, 2);
    wait_drain(200);

`ifdef DHA_ARB_WATCHDOG_EN
    // Src 1 stalls after beat 1; watchdog aborts, remainder drained
    send_pkt(1, 4, 112, 2'd0, 2, 20, 2);
    ab.src = 1; ab.sop = 1'b0; ab.eop = 1'b1; ab.data = '0;
    ab.empty = 2'd0; ab.err = 1'b1; ab.dly = 0;
    exp_q.push_back(ab);
    wait_drain(300);
    send_pkt(0, 3, 113, 2'd0, -1, 0, 3);
    wait_drain(200);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
